// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the load/store path: funct3 encodings and the
// LSU sequencing states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    LSU_IDLE    = 3'd0,
    LSU_READ    = 3'd1,
    LSU_CAPTURE = 3'd2,
    LSU_WRITE   = 3'd3,
    LSU_RESP    = 3'd4
  } lsu_state_t;

  // Bit offset of a byte lane inside a 32-bit word.
  function automatic logic [4:0] lane_shift(input logic [1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// and legality/alignment checking of a request.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_val,
  output logic [31:0] o_merged,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_old_word[lane_shift(i_addr_lo) +: 8];
    w_half = i_old_word[lane_shift({i_addr_lo[1], 1'b0}) +: 16];
  end

  always_comb begin
    o_load_val = 32'h0;
    case (i_funct3)
      F3_LB:   o_load_val = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_val = {{16{w_half[15]}}, w_half};
      F3_LW:   o_load_val = i_old_word;
      F3_LBU:  o_load_val = {24'h0, w_byte};
      F3_LHU:  o_load_val = {16'h0, w_half};
      default: o_load_val = 32'h0;
    endcase
  end

  // Only the addressed lane(s) are replaced; the rest of the old word survives.
  always_comb begin
    o_merged = i_old_word;
    case (i_funct3)
      F3_SB:   o_merged[lane_shift(i_addr_lo) +: 8] = i_wdata[7:0];
      F3_SH:   o_merged[lane_shift({i_addr_lo[1], 1'b0}) +: 16] = i_wdata[15:0];
      F3_SW:   o_merged = i_wdata;
      default: o_merged = i_old_word;
    endcase
  end

  always_comb begin
    o_err = 1'b1;
    if (i_we) begin
      case (i_funct3)
        F3_SB:   o_err = 1'b0;
        F3_SH:   o_err = i_addr_lo[0];
        F3_SW:   o_err = (i_addr_lo != 2'b00);
        default: o_err = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_LB, F3_LBU: o_err = 1'b0;
        F3_LH, F3_LHU: o_err = i_addr_lo[0];
        F3_LW:         o_err = (i_addr_lo != 2'b00);
        default:       o_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts byte/half/word requests into word-aligned accesses
// on a word-only memory port, with read-modify-write for sub-word stores.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic [2:0]      r_funct3;
  logic            r_we;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic            r_err;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;

  logic            w_idle;
  logic            w_accept;
  logic [2:0]      w_funct3;
  logic            w_we;
  logic [1:0]      w_addr_lo;
  logic [XLEN-1:0] w_load_val;
  logic [XLEN-1:0] w_merged;
  logic            w_err;

  assign w_idle   = (r_state == LSU_IDLE);
  assign w_accept = w_idle && req_valid;

  // Legality is judged on the live request in IDLE, lane work on the captured one.
  assign w_funct3  = w_idle ? req_funct3    : r_funct3;
  assign w_we      = w_idle ? req_we        : r_we;
  assign w_addr_lo = w_idle ? req_addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_funct3   (w_funct3),
    .i_we       (w_we),
    .i_addr_lo  (w_addr_lo),
    .i_old_word (mem_rdata),
    .i_wdata    (r_wdata),
    .o_load_val (w_load_val),
    .o_merged   (w_merged),
    .o_err      (w_err)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (req_valid) begin
          if (w_err)                              w_next = LSU_RESP;
          else if (req_we && req_funct3 == F3_SW) w_next = LSU_WRITE;
          else                                    w_next = LSU_READ;
        end
      end
      LSU_READ:    w_next = LSU_CAPTURE;
      LSU_CAPTURE: w_next = r_we ? LSU_WRITE : LSU_RESP;
      LSU_WRITE:   w_next = LSU_RESP;
      LSU_RESP:    w_next = LSU_IDLE;
      default:     w_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= LSU_IDLE;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state  <= w_next;
      r_mem_we <= (w_next == LSU_WRITE);

      if (w_next == LSU_IDLE || w_next == LSU_RESP)
        r_mem_addr <= '0;
      else if (w_idle)
        r_mem_addr <= {req_addr[XLEN-1:2], 2'b00};

      if (w_next == LSU_WRITE)
        r_mem_wdata <= w_idle ? req_wdata : w_merged;
      else
        r_mem_wdata <= '0;

      if (w_accept) begin
        r_rdata <= '0;
        r_err   <= w_err;
      end else if (r_state == LSU_CAPTURE && !r_we) begin
        r_rdata <= w_load_val;
      end else if (r_state == LSU_RESP) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Request payload only matters after acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_funct3  <= req_funct3;
      r_we      <= req_we;
      r_addr_lo <= req_addr[1:0];
      r_wdata   <= req_wdata;
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == LSU_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous-read word RAM
// standing in for memory_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Word RAM: read data valid one cycle after the address is presented.
  logic        init_ram;
  logic [31:0] ram [0:15];
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      ram[1] <= 32'hDEADBEEF;
    end else if (mem_we) begin
      ram[mem_addr[5:2]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[5:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          t_wait;
  int          t_resp_cyc;
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_we_cnt;
  int          t_we_cyc;
  logic [31:0] t_we_data;
  logic [31:0] t_addr1;

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    t_wait = 0;
    while (!req_ready && t_wait < 10) begin
      @(posedge clk);
      @(negedge clk);
      t_wait++;
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5555_5555;
    t_resp_cyc = -1;
    t_rdata    = 32'hX;
    t_err      = 1'bX;
    t_we_cnt   = 0;
    t_we_cyc   = -1;
    t_we_data  = 32'h0;
    t_addr1    = 32'hX;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) t_addr1 = mem_addr;
      if (mem_we) begin
        t_we_cnt++;
        t_we_cyc  = k;
        t_we_data = mem_wdata;
      end
      if (resp_valid) begin
        t_resp_cyc = k;
        t_rdata    = resp_rdata;
        t_err      = resp_err;
        break;
      end
    end
  endtask

  task automatic check_resp(input string tag, input int cyc, input logic [31:0] rdata,
                            input logic err, input int we_cnt);
    check({tag, " resp_cycle"}, t_resp_cyc, cyc);
    check({tag, " rdata"}, t_rdata, rdata);
    check({tag, " err"}, {31'h0, t_err}, {31'h0, err});
    check({tag, " we_count"}, t_we_cnt, we_cnt);
  endtask

  int n_we;
  int n_resp;

  initial begin
    rst        = 1'b0;
    init_ram   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);

    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", {31'h0, resp_err}, 32'h0);
    check("reset mem_we", {31'h0, mem_we}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);

    rst      = 1'b1;
    init_ram = 1'b0;
    @(negedge clk);

    // Word load
    run_req(1'b0, 3'b010, 32'h0010_0004, 32'h0);
    check_resp("LW", 3, 32'hDEADBEEF, 1'b0, 0);
    check("LW read addr", t_addr1, 32'h0010_0004);

    // Byte/halfword extraction and extension
    run_req(1'b0, 3'b000, 32'h0010_0007, 32'h0);
    check_resp("LB", 3, 32'hFFFFFFDE, 1'b0, 0);
    run_req(1'b0, 3'b100, 32'h0010_0007, 32'h0);
    check_resp("LBU", 3, 32'h000000DE, 1'b0, 0);
    run_req(1'b0, 3'b001, 32'h0010_0006, 32'h0);
    check_resp("LH", 3, 32'hFFFFDEAD, 1'b0, 0);
    check("LH read addr", t_addr1, 32'h0010_0004);
    run_req(1'b0, 3'b101, 32'h0010_0006, 32'h0);
    check_resp("LHU", 3, 32'h0000DEAD, 1'b0, 0);

    // Sub-word store read-modify-write
    run_req(1'b1, 3'b000, 32'h0010_0005, 32'h1234_56A5);
    check_resp("SB", 4, 32'h0, 1'b0, 1);
    check("SB we cycle", t_we_cyc, 3);
    check("SB wdata", t_we_data, 32'hDEADA5EF);
    check("SB read addr", t_addr1, 32'h0010_0004);
    run_req(1'b0, 3'b010, 32'h0010_0004, 32'h0);
    check_resp("LW after SB", 3, 32'hDEADA5EF, 1'b0, 0);

    // Misaligned and illegal requests
    run_req(1'b1, 3'b001, 32'h0010_0003, 32'hFFFF_FFFF);
    check_resp("SH misaligned", 1, 32'h0, 1'b1, 0);
    check("SH misaligned addr", t_addr1, 32'h0);
    run_req(1'b0, 3'b010, 32'h0010_0002, 32'h0);
    check_resp("LW misaligned", 1, 32'h0, 1'b1, 0);
    check("LW misaligned addr", t_addr1, 32'h0);
    run_req(1'b0, 3'b011, 32'h0010_0004, 32'h0);
    check_resp("funct3 011", 1, 32'h0, 1'b1, 0);
    check("funct3 011 addr", t_addr1, 32'h0);

    // SW then immediate LW of the same word
    run_req(1'b1, 3'b010, 32'h0010_0008, 32'hCAFEF00D);
    check_resp("SW", 2, 32'h0, 1'b0, 1);
    check("SW we cycle", t_we_cyc, 1);
    check("SW wdata", t_we_data, 32'hCAFEF00D);
    check("SW write addr", t_addr1, 32'h0010_0008);
    run_req(1'b0, 3'b010, 32'h0010_0008, 32'h0);
    check("back-to-back wait", t_wait, 1);
    check_resp("LW after SW", 3, 32'hCAFEF00D, 1'b0, 0);

    // Reset during CAPTURE of an SB
    @(negedge clk);
    check("pre-abort ready", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0010_0009;
    req_wdata  = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort mid-op addr", mem_addr, 32'h0010_0008);
    rst = 1'b0;
    #1;
    check("abort mem_we", {31'h0, mem_we}, 32'h0);
    check("abort mem_addr", mem_addr, 32'h0);
    check("abort mem_wdata", mem_wdata, 32'h0);
    check("abort resp_valid", {31'h0, resp_valid}, 32'h0);
    check("abort resp_rdata", resp_rdata, 32'h0);
    check("abort req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    n_we = 0;
    n_resp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_we) n_we++;
      if (resp_valid) n_resp++;
    end
    check("post-abort we pulses", n_we, 0);
    check("post-abort resp pulses", n_resp, 0);
    check("post-abort ready", {31'h0, req_ready}, 32'h1);
    run_req(1'b0, 3'b010, 32'h0010_0008, 32'h0);
    check_resp("LW after abort", 3, 32'hCAFEF00D, 1'b0, 0);

    // Halfword store into the upper lane, then positive LH
    run_req(1'b1, 3'b001, 32'h0010_000A, 32'hABCD_1234);
    check_resp("SH", 4, 32'h0, 1'b0, 1);
    check("SH we cycle", t_we_cyc, 3);
    check("SH wdata", t_we_data, 32'h1234F00D);
    run_req(1'b0, 3'b001, 32'h0010_000A, 32'h0);
    check_resp("LH positive", 3, 32'h00001234, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and `memory_unit`; turns CPU load/store requests (byte, halfword, word; signed/unsigned) into word-aligned accesses on the 32-bit word-only memory port. Loads extract and extend the addressed lane. Sub-word stores run a read-modify-write sequence. Misaligned or illegal requests are flagged without touching memory.

## Interface
Parameters:
- `XLEN`, 32, data and address width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU accepts; equals (state == IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low lanes.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal funct3; valid with `resp_valid`.
- `mem_we`  out  1  write enable to `memory_unit`.
- `mem_addr`  out  32  word address to `memory_unit`, with bits [1:0] = 0.
- `mem_wdata`  out  32  write word.
- `mem_rdata`  in  32  read word; valid one cycle after `mem_addr` is presented.

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. `addr`, `funct3`, `we` and `wdata` are captured on that edge. Request inputs are ignored while not in IDLE.
- Byte order is little-endian. Lane index is `addr[1:0]`.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Every other funct3 is illegal and sets `resp_err`.
- Alignment rules:
  - Halfword access requires `addr[0] == 0`.
  - Word access requires `addr[1:0] == 0`.
  - Byte access is always aligned.
- States:
  - IDLE: on accept, an error goes to RESP with `err` set. SW goes to WRITE. Every other access goes to READ.
  - READ: drive `mem_addr = {addr[31:2],2'b00}` with `mem_we = 0`. Next state is CAPTURE.
  - CAPTURE: `mem_rdata` is valid.
    - Load: register the extracted and extended result, then go to RESP.
    - SB/SH: register the merged word (new lane(s) replace the old, other lanes kept), then go to WRITE.
  - WRITE: `mem_we = 1` for exactly this cycle, with `mem_wdata` = merged word (SW: `req_wdata`). Next state is RESP.
  - RESP: `resp_valid = 1` for one cycle, then IDLE.
- Extension rules:
  - LB/LH sign-extend from bit 7/15 of the lane.
  - LBU/LHU zero-extend.
- `mem_addr` holds the word address in READ, CAPTURE and WRITE, and 0 otherwise.
- `mem_we` is 0 in every state except WRITE.
- Error path: no memory access and `resp_rdata = 0`.
- RESP is not back-pressured; the consumer must take the pulse.

## Timing
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0.
- Latencies, counting the accept edge as cycle 0; the number is the cycle in which `resp_valid` is high:
  - Error: cycle 1.
  - SW: cycle 2, with `mem_we` high in cycle 1.
  - Load: cycle 3.
  - SB/SH: cycle 4, with `mem_we` high in cycle 3.
- Back-to-back: a new request is accepted in the cycle after RESP (IDLE). Minimum issue interval is resp latency + 1.
- Reset mid-operation: the FSM returns to IDLE immediately and `mem_we` drops asynchronously. A write that has already completed is not undone. No `resp_valid` is produced for the aborted request.
- `mem_wdata` and `mem_addr` are registered outputs, so there are no combinational paths from `req_*` to `mem_*`.

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - LSU state encoding (IDLE, READ, CAPTURE, WRITE, RESP).
- Sub-module `lsu_align` is purely combinational:
  - Inputs: `funct3`, `addr[1:0]`, old word, store data.
  - Outputs: extended load value, merged store word, misaligned/illegal flag.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- LW at 0x0010_0004 with RAM word 0xDEADBEEF -> `resp_valid` in cycle 3, `resp_rdata` = 0xDEADBEEF, `resp_err` = 0, `mem_we` never high.
- LB / LBU at 0x0010_0007 on the same word -> 0xFFFFFFDE / 0x000000DE. LH / LHU at 0x0010_0006 -> 0xFFFFDEAD / 0x0000DEAD.
- SB at 0x0010_0005 with `req_wdata` 0x123456A5 -> `mem_we` only in cycle 3, `mem_wdata` 0xDEADA5EF, `resp_valid` in cycle 4; a later LW returns 0xDEADA5EF.
- SH at 0x0010_0003, then LW at 0x0010_0002, then funct3 = 011 -> each gives `resp_err` = 1 in cycle 1, `resp_rdata` = 0, no `mem_we`, no READ address driven.
- SW 0xCAFEF00D to 0x0010_0008 followed immediately by LW of the same address -> `mem_we` in cycle 1, resp in cycle 2, second request accepted in cycle 3 and returns 0xCAFEF00D.
- `rst` pulled low during CAPTURE of an SB -> outputs take their reset values immediately, no `mem_we` pulse, no `resp_valid`, memory word unchanged, `req_ready` = 1 after release.
